// File: rtl/fp_int_mul_sched.sv
// Sequencer in front of the bit-serial fp16 x intN multiplier: programs precision,
// then streams each weight MSB-first while holding its activation, and counts products.
module fp_int_mul_sched #(
  parameter int ACT_WIDTH = 16,
  parameter int W_MAX     = 8,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [3:0]           cfg_precision,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACT_WIDTH-1:0] in_act,
  input  logic [W_MAX-1:0]     in_w,
  output logic [ACT_WIDTH-1:0] mul_act,
  output logic                 mul_w,
  output logic                 mul_valid,
  output logic                 mul_set,
  output logic [3:0]           mul_precision,
  input  logic                 mul_start_acc,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] done_count
);
  localparam int K_W = (W_MAX > 2) ? $clog2(W_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SET    = 3'd1,
    S_LOAD   = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           prec_q, prec_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] issued_q, issued_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACT_WIDTH-1:0] act_q, act_d;
  logic [W_MAX-1:0]     w_q, w_d;
  logic [K_W-1:0]       k_q, k_d;

  logic                 cfg_ready_q, cfg_ready_d;
  logic                 in_ready_q, in_ready_d;
  logic                 mul_w_q, mul_w_d;
  logic                 mul_valid_q, mul_valid_d;
  logic                 mul_set_q, mul_set_d;
  logic [3:0]           mul_prec_q, mul_prec_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 cfg_hs_s, in_hs_s, last_bit_s, count_en_s;

  function automatic logic [3:0] clamp_prec(input logic [3:0] p);
    if (p < 4'd2) begin
      clamp_prec = 4'd2;
    end else if (p > 4'(W_MAX)) begin
      clamp_prec = 4'(W_MAX);
    end else begin
      clamp_prec = p;
    end
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prec_q   <= 4'd0;
      len_q    <= {LEN_WIDTH{1'b0}};
      issued_q <= {LEN_WIDTH{1'b0}};
      cnt_q    <= {LEN_WIDTH{1'b0}};
      act_q    <= {ACT_WIDTH{1'b0}};
      w_q      <= {W_MAX{1'b0}};
      k_q      <= {K_W{1'b0}};
    end else begin
      state_q  <= state_d;
      prec_q   <= prec_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      w_q      <= w_d;
      k_q      <= k_d;
    end
  end

  // Next-state, operand latching and product counting
  always_comb begin
    state_d    = state_q;
    prec_d     = prec_q;
    len_d      = len_q;
    issued_d   = issued_q;
    act_d      = act_q;
    w_d        = w_q;
    k_d        = k_q;
    cfg_hs_s   = cfg_valid & cfg_ready_q;
    in_hs_s    = in_valid & in_ready_q;
    last_bit_s = (k_q == {K_W{1'b0}});
    count_en_s = mul_start_acc &
                 ((state_q == S_STREAM) || (state_q == S_LOAD) || (state_q == S_DRAIN));

    if (count_en_s) begin
      cnt_d = cnt_q + LEN_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cfg_hs_s) begin
          prec_d   = clamp_prec(cfg_precision);
          len_d    = cfg_len;
          issued_d = {LEN_WIDTH{1'b0}};
          cnt_d    = {LEN_WIDTH{1'b0}};
          if (cfg_len == {LEN_WIDTH{1'b0}}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SET;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SET: state_d = S_LOAD;
      S_LOAD: begin
        if (in_hs_s) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_STREAM: begin
        if (!last_bit_s) begin
          k_d     = k_q - K_W'(1);
          state_d = S_STREAM;
        end else if (issued_q == len_q) begin
          state_d = S_DRAIN;
        end else if (in_hs_s) begin
          state_d = S_STREAM;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (cnt_q == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // in_ready is only ever high in LOAD or on a last bit with operands left
    if (in_hs_s) begin
      act_d    = in_act;
      w_d      = in_w;
      k_d      = K_W'(prec_q - 4'd1);
      issued_d = issued_q + LEN_WIDTH'(1);
    end else begin
      issued_d = issued_d;
    end
  end

  // Output values for the next cycle, derived from the next state
  always_comb begin
    cfg_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    mul_valid_d = (state_d == S_STREAM);
    mul_set_d   = (state_d == S_SET);
    done_d      = (state_d == S_DONE);
    in_ready_d  = (state_d == S_LOAD) ||
                  ((state_d == S_STREAM) && (k_d == {K_W{1'b0}}) && (issued_d < len_d));
    if (state_d == S_STREAM) begin
      mul_w_d = w_d[k_d];
    end else begin
      mul_w_d = mul_w_q;
    end
    if (state_d == S_SET) begin
      mul_prec_d = prec_d;
    end else begin
      mul_prec_d = mul_prec_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      mul_w_q     <= 1'b0;
      mul_valid_q <= 1'b0;
      mul_set_q   <= 1'b0;
      mul_prec_q  <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
      in_ready_q  <= in_ready_d;
      mul_w_q     <= mul_w_d;
      mul_valid_q <= mul_valid_d;
      mul_set_q   <= mul_set_d;
      mul_prec_q  <= mul_prec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign in_ready      = in_ready_q;
  assign mul_act       = act_q;
  assign mul_w         = mul_w_q;
  assign mul_valid     = mul_valid_q;
  assign mul_set       = mul_set_q;
  assign mul_precision = mul_prec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign done_count    = cnt_q;

endmodule
